mem_seq: RTL and testbench
==========================

# mem_seq

Synchronous memory-access sequencer for the multi-cycle CPU. Sits between the control unit and the data-memory path (address register, data memory, data register, output enables). Converts one load/store request into the ordered strobe sequence, one strobe per cycle, and returns read data with a completion pulse. Replaces hand-timed `#` delays with clock-aligned, state-decoded strobes.

## Interface
Parameters:
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: data width.
- `DM_AW`, 8: implemented memory index width (256 words).

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: access request, sampled only while `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `addr` in `ADDR_W`: word index.
- `wdata` in `DATA_W`: store data.
- `ready` out 1: idle, request can be accepted.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; out-of-range access.
- `rdata` out `DATA_W`: load result, held until the next load completes.
- `mar_wr` out 1: address-register write strobe.
- `mar_in` out `ADDR_W`: latched address.
- `dm_r` out 1: memory read strobe.
- `dm_w` out 1: memory write strobe.
- `dm_wdata` out `DATA_W`: latched store data.
- `dm_rdata` in `DATA_W`: memory read data.
- `mem_oe` out 1: memory output enable.
- `mdr_wr` out 1: data-register write strobe.
- `mdr_oe` out 1: data-register output enable.

## Operation
- States: IDLE, ADDR, RD, CAP, WR, DONE. Encoded as a registered enum.
- All strobes are decoded from the registered state only. No combinational path from `req` to any output.
- IDLE:
  - `ready`=1.
  - On `req`=1: latch `addr` into `mar_in`, `wdata` into `dm_wdata`, and `we` internally. Next state is ADDR.
- ADDR: `mar_wr`=1. Next state is RD if load, WR if store.
- RD: `dm_r`=1. Next state is CAP.
- CAP:
  - `mem_oe`=1 and `mdr_wr`=1.
  - `rdata` <= `dm_rdata` at the end of the cycle.
  - Next state is DONE.
- WR: `dm_w`=1. Next state is DONE.
- DONE:
  - `done`=1. `mdr_oe`=1 for loads only.
  - Next state is IDLE.
- `req` outside IDLE is ignored (not queued). `ready`=0 in DONE, so back-to-back accesses are separated by at least one IDLE cycle.
- `mar_in` and `dm_wdata` hold their latched values until the next accept.
- Reset values:
  - State is IDLE.
  - `ready`=1 (follows IDLE).
  - All strobes, `done`, `err` = 0.
  - `rdata`, `mar_in`, `dm_wdata` = 0.
- Reset mid-access: the access is dropped, no `done` is issued, and no further strobe fires. A `dm_w` in progress in that cycle is not retracted.

## Timing
- Request accepted at edge E0.
- Load: `mar_wr` in cycle 1, `dm_r` in cycle 2, `mdr_wr`/`mem_oe` in cycle 3, `done` in cycle 4. `rdata` is valid from cycle 4 on.
- Store: `mar_wr` in cycle 1, `dm_w` in cycle 2, `done` in cycle 3.
- Each strobe is high for exactly one cycle. No two memory strobes overlap.
- Throughput: one load per 5 cycles, one store per 4 cycles.

## Configuration
- `MEM_SEQ_BOUNDS_CHK_EN` defined:
  - At accept, `addr[ADDR_W-1:DM_AW]` != 0 sends the FSM directly to DONE.
  - `done`=1 and `err`=1 in cycle 1.
  - No `mar_wr`, `dm_r` or `dm_w` is issued.
  - `rdata` is unchanged.
- Macro undefined:
  - Upper address bits are passed through in `mar_in` unchecked.
  - `err` is tied to 0.

## Structure
- Shared package `mem_seq_pkg`:
  - State enum `mem_seq_state_t`.
  - Constant `DM_DEPTH_LOG2` = 8 (shared with the memory model).
  - Access-type constants `ACC_LOAD`=0, `ACC_STORE`=1.
- Single module. No sub-module: the FSM plus latch registers are too small to split.

## Test plan
- Load: memory word 17 preset to 1; `req`=1, `we`=0, `addr`=17 -> strobes in cycles 1/2/3, `done` in cycle 4, `rdata`=1.
- Store then load: store `addr`=16, `wdata`=31 -> `dm_w` in cycle 2, `done` in cycle 3. A following load of 16 returns 31.
- Busy request: assert `req` continuously through a load -> exactly one access. A second access is accepted only in the IDLE cycle after `done`.
- Reset mid-access: `rst` in cycle 2 of a load -> no `mdr_wr`, no `done`. Next cycle: IDLE, `ready`=1, `rdata`=0.
- With `MEM_SEQ_BOUNDS_CHK_EN`: load `addr`=0x100 -> `done`=1 and `err`=1 in cycle 1, no memory strobe, `rdata` unchanged.
- Without the macro: same stimulus -> normal 4-cycle load, `mar_in`=0x100, `err`=0.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and constants for the memory-access sequencer
// Contents: mem_seq_state_t state enum, DM_DEPTH_LOG2 memory depth, ACC_LOAD/ACC_STORE access types.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } mem_seq_state_t;

    // Shared with the data-memory model: 256 implemented words.
    localparam int DM_DEPTH_LOG2 = 8;

    localparam logic ACC_LOAD  = 1'b0;
    localparam logic ACC_STORE = 1'b1;

endpackage

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - load/store request to one-strobe-per-cycle memory sequence
// Ports: clk, rst (sync, active-high); request side req/we/addr/wdata, ready/done/err/rdata;
//        memory side mar_wr/mar_in, dm_r/dm_w/dm_wdata/dm_rdata, mem_oe, mdr_wr, mdr_oe.
// Option macro MEM_SEQ_BOUNDS_CHK_EN: reject addresses above the implemented memory
// with a cycle-1 done+err and no memory strobes; undefined ties err to 0.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DM_AW  = DM_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mar_wr,
    output logic [ADDR_W-1:0] mar_in,
    output logic              dm_r,
    output logic              dm_w,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              mem_oe,
    output logic              mdr_wr,
    output logic              mdr_oe
);

    mem_seq_state_t state;
    logic           acc_we;

`ifdef MEM_SEQ_BOUNDS_CHK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Every output is registered alongside the state it belongs to, so a strobe
    // is high exactly in the cycle its state is held and req never reaches an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc_we   <= ACC_LOAD;
            ready    <= 1'b1;
            done     <= 1'b0;
            mar_wr   <= 1'b0;
            dm_r     <= 1'b0;
            dm_w     <= 1'b0;
            mem_oe   <= 1'b0;
            mdr_wr   <= 1'b0;
            mdr_oe   <= 1'b0;
            rdata    <= '0;
            mar_in   <= '0;
            dm_wdata <= '0;
`ifdef MEM_SEQ_BOUNDS_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            ready  <= 1'b0;
            done   <= 1'b0;
            mar_wr <= 1'b0;
            dm_r   <= 1'b0;
            dm_w   <= 1'b0;
            mem_oe <= 1'b0;
            mdr_wr <= 1'b0;
            mdr_oe <= 1'b0;
`ifdef MEM_SEQ_BOUNDS_CHK_EN
            err_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (req) begin
                        // Upper bits are carried through untouched; only the
                        // bounds-check build looks at them.
                        mar_in   <= {addr[ADDR_W-1:DM_AW], addr[DM_AW-1:0]};
                        dm_wdata <= wdata;
                        acc_we   <= we;
                        ready    <= 1'b0;
                        state    <= ST_ADDR;
                        mar_wr   <= 1'b1;
`ifdef MEM_SEQ_BOUNDS_CHK_EN
                        if (|addr[ADDR_W-1:DM_AW]) begin
                            state  <= ST_DONE;
                            mar_wr <= 1'b0;
                            done   <= 1'b1;
                            err_q  <= 1'b1;
                        end
`endif
                    end
                end
                ST_ADDR: begin
                    if (acc_we == ACC_STORE) begin
                        state <= ST_WR;
                        dm_w  <= 1'b1;
                    end else begin
                        state <= ST_RD;
                        dm_r  <= 1'b1;
                    end
                end
                ST_RD: begin
                    state  <= ST_CAP;
                    mem_oe <= 1'b1;
                    mdr_wr <= 1'b1;
                end
                ST_CAP: begin
                    rdata  <= dm_rdata;
                    state  <= ST_DONE;
                    done   <= 1'b1;
                    mdr_oe <= 1'b1;
                end
                ST_WR: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - directed self-checking bench for mem_seq with a 256-word memory model
module tb_mem_seq;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready, done, err;
    logic [DATA_W-1:0] rdata;
    logic              mar_wr, dm_r, dm_w, mem_oe, mdr_wr, mdr_oe;
    logic [ADDR_W-1:0] mar_in;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    // Preload port for the memory model, driven only while the DUT is idle.
    logic              pre_en;
    logic [7:0]        pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_q;

    int checks = 0;
    int errors = 0;

    // {mar_wr, dm_r, dm_w, mem_oe, mdr_wr, mdr_oe, done, err}
    logic [7:0] strb;
    assign strb = {mar_wr, dm_r, dm_w, mem_oe, mdr_wr, mdr_oe, done, err};

    always #5 clk = ~clk;

    mem_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DM_AW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mar_wr(mar_wr), .mar_in(mar_in), .dm_r(dm_r), .dm_w(dm_w),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .mem_oe(mem_oe),
        .mdr_wr(mdr_wr), .mdr_oe(mdr_oe)
    );

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (dm_w) mem[mar_in[7:0]] <= dm_wdata;
        if (dm_r) rd_q <= mem[mar_in[7:0]];
    end
    assign dm_rdata = rd_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        step(); step();
        check("rst_ready", ready, 1);
        check("rst_strobes", strb, 8'h00);
        check("rst_rdata", rdata, 0);
        check("rst_mar_in", mar_in, 0);
        check("rst_dm_wdata", dm_wdata, 0);
        rst = 1'b0;
        preload(8'd17, 32'd1);
        preload(8'd0, 32'h77);
        preload(8'd5, 32'hA5A5);
        preload(8'd6, 32'h6666);
        check("idle_ready", ready, 1);

        // Load of word 17.
        req = 1'b1; we = 1'b0; addr = 32'd17;
        step(); req = 1'b0;
        check("ld_c1_strb", strb, 8'b1000_0000);
        check("ld_c1_mar_in", mar_in, 17);
        check("ld_c1_ready", ready, 0);
        step(); check("ld_c2_strb", strb, 8'b0100_0000);
        step(); check("ld_c3_strb", strb, 8'b0001_1000);
        step(); check("ld_c4_strb", strb, 8'b0000_0110);
        check("ld_c4_rdata", rdata, 1);
        step(); check("ld_c5_strb", strb, 8'h00);
        check("ld_c5_ready", ready, 1);

        // Store 31 to word 16, then load it back.
        req = 1'b1; we = 1'b1; addr = 32'd16; wdata = 32'd31;
        step(); req = 1'b0;
        check("st_c1_strb", strb, 8'b1000_0000);
        check("st_c1_dm_wdata", dm_wdata, 31);
        step(); check("st_c2_strb", strb, 8'b0010_0000);
        step(); check("st_c3_strb", strb, 8'b0000_0010);
        check("st_mem16", mem[16], 31);
        check("st_rdata_held", rdata, 1);
        step(); check("st_c4_ready", ready, 1);
        req = 1'b1; we = 1'b0; addr = 32'd16;
        step(); req = 1'b0;
        step(); step(); step();
        check("ld16_done", done, 1);
        check("ld16_rdata", rdata, 31);
        step();

        // req held high through a load: one access, next accept after the IDLE cycle.
        req = 1'b1; we = 1'b0; addr = 32'd5;
        step();
        check("busy_c1_mar_wr", mar_wr, 1);
        addr = 32'd6;
        step(); check("busy_c2_strb", strb, 8'b0100_0000);
        step(); check("busy_c3_mar_in", mar_in, 5);
        check("busy_c3_strb", strb, 8'b0001_1000);
        step(); check("busy_c4_strb", strb, 8'b0000_0110);
        check("busy_c4_ready", ready, 0);
        check("busy_c4_rdata", rdata, 32'hA5A5);
        step(); check("busy_c5_ready", ready, 1);
        check("busy_c5_strb", strb, 8'h00);
        step(); req = 1'b0;
        check("busy_c6_mar_wr", mar_wr, 1);
        check("busy_c6_mar_in", mar_in, 6);
        step(); step(); step();
        check("busy2_rdata", rdata, 32'h6666);
        step();

        // Reset in cycle 2 of a load.
        req = 1'b1; we = 1'b0; addr = 32'd17;
        step(); req = 1'b0;
        step(); check("rstmid_c2_dm_r", dm_r, 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        check("rstmid_ready", ready, 1);
        check("rstmid_strb", strb, 8'h00);
        check("rstmid_rdata", rdata, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (mdr_wr || done) seen++;
            end
            check("rstmid_no_done", seen, 0);
        end

        // Out-of-range load, word 0x100.
        req = 1'b1; we = 1'b0; addr = 32'h100;
        step(); req = 1'b0;
`ifdef MEM_SEQ_BOUNDS_CHK_EN
        check("oob_c1_strb", strb, 8'b0000_0011);
        check("oob_c1_rdata", rdata, 0);
        step(); check("oob_c2_ready", ready, 1);
        check("oob_c2_strb", strb, 8'h00);
        check("oob_c2_rdata", rdata, 0);
`else
        check("oob_c1_strb", strb, 8'b1000_0000);
        check("oob_c1_mar_in", mar_in, 32'h100);
        step(); check("oob_c2_strb", strb, 8'b0100_0000);
        step(); check("oob_c3_strb", strb, 8'b0001_1000);
        step(); check("oob_c4_strb", strb, 8'b0000_0110);
        check("oob_c4_rdata", rdata, 32'h77);
        step(); check("oob_c5_ready", ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
